// File: rtl/branch_target_table.sv
// Branch-target table: forward index->target lookup plus a sequential
// reverse search that returns the lowest index holding a given target.
module branch_target_table #(
    parameter int unsigned D     = 12,
    parameter int unsigned A     = 8,
    parameter int unsigned DEPTH = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         wr_valid,
    output logic         wr_ready,
    input  logic [A-1:0] wr_idx,
    input  logic [D-1:0] wr_target,
    input  logic [A-1:0] rd_addr,
    output logic [D-1:0] rd_target,
    input  logic         srch_valid,
    output logic         srch_ready,
    input  logic [D-1:0] srch_target,
    output logic         srch_done,
    output logic         srch_hit,
    output logic [A-1:0] srch_idx,
    output logic         busy
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [1:0] S_INIT   = 2'd0;
    localparam logic [1:0] S_IDLE   = 2'd1;
    localparam logic [1:0] S_SEARCH = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    logic [1:0]    state;
    logic [1:0]    state_nxt;
    logic [PW-1:0] ptr;
    logic [PW-1:0] ptr_nxt;
    logic [D-1:0]  key;
    logic [D-1:0]  key_nxt;
    logic          hit_nxt;
    logic [A-1:0]  idx_nxt;

    logic [D-1:0]  mem [DEPTH];

    logic          wr_fire_c;
    logic          srch_fire_c;
    logic          init_clr_c;
    logic          wr_in_range_c;
    logic          rd_in_range_c;
    logic          last_c;

    // Handshake and status decode from the current state
    always_comb begin
        wr_ready      = (state == S_IDLE);
        srch_ready    = (state == S_IDLE) && !wr_valid;
        srch_done     = (state == S_DONE);
        busy          = (state == S_INIT) || (state == S_SEARCH);
        wr_in_range_c = (wr_idx < A'(DEPTH));
        rd_in_range_c = (rd_addr < A'(DEPTH));
        wr_fire_c     = rst_n && wr_valid && (state == S_IDLE) && wr_in_range_c;
        srch_fire_c   = srch_valid && (state == S_IDLE) && !wr_valid;
        init_clr_c    = rst_n && (state == S_INIT);
        last_c        = (ptr == PW'(DEPTH - 1));
    end

    // Forward lookup; cleared table reads as zero while initialising
    always_comb begin
        rd_target = '0;
        if (state != S_INIT && rd_in_range_c) begin
            rd_target = mem[rd_addr[PW-1:0]];
        end
    end

    // Next-state logic: clear sweep, search launch and linear compare walk
    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        key_nxt   = key;
        hit_nxt   = srch_hit;
        idx_nxt   = srch_idx;
        case (state)
            S_INIT: begin
                ptr_nxt = ptr + PW'(1);
                if (last_c) begin
                    ptr_nxt   = '0;
                    state_nxt = S_IDLE;
                end
            end
            S_IDLE: begin
                if (srch_fire_c) begin
                    key_nxt   = srch_target;
                    ptr_nxt   = '0;
                    hit_nxt   = 1'b0;
                    idx_nxt   = '0;
                    state_nxt = S_SEARCH;
                end
            end
            S_SEARCH: begin
                if (mem[ptr] == key) begin
                    hit_nxt   = 1'b1;
                    idx_nxt   = A'(ptr);
                    state_nxt = S_DONE;
                end else if (last_c) begin
                    hit_nxt   = 1'b0;
                    idx_nxt   = '0;
                    state_nxt = S_DONE;
                end else begin
                    ptr_nxt = ptr + PW'(1);
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_INIT;
                ptr_nxt   = '0;
            end
        endcase
    end

    // State and result registers; reset abandons any search in flight
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_INIT;
            ptr      <= '0;
            key      <= '0;
            srch_hit <= 1'b0;
            srch_idx <= '0;
        end else begin
            state    <= state_nxt;
            ptr      <= ptr_nxt;
            key      <= key_nxt;
            srch_hit <= hit_nxt;
            srch_idx <= idx_nxt;
        end
    end

    // Table storage: clear sweep during INIT, loader writes in IDLE
    always_ff @(posedge clk) begin
        if (init_clr_c) begin
            mem[ptr] <= '0;
        end else if (wr_fire_c) begin
            mem[wr_idx[PW-1:0]] <= wr_target;
        end
    end

endmodule

// File: tb/tb_branch_target_table.sv
// Directed and randomized checks of branch_target_table against a table model.
module tb_branch_target_table;

    logic        clk;
    logic        rst_n;
    logic        wr_valid;
    logic        wr_ready;
    logic [7:0]  wr_idx;
    logic [11:0] wr_target;
    logic [7:0]  rd_addr;
    logic [11:0] rd_target;
    logic        srch_valid;
    logic        srch_ready;
    logic [11:0] srch_target;
    logic        srch_done;
    logic        srch_hit;
    logic [7:0]  srch_idx;
    logic        busy;

    int unsigned checks = 0;
    int unsigned passes = 0;

    // Reference table: 256 logical indices, only the first 32 retain writes
    logic [11:0] model [256];

    branch_target_table dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_idx      (wr_idx),
        .wr_target   (wr_target),
        .rd_addr     (rd_addr),
        .rd_target   (rd_target),
        .srch_valid  (srch_valid),
        .srch_ready  (srch_ready),
        .srch_target (srch_target),
        .srch_done   (srch_done),
        .srch_hit    (srch_hit),
        .srch_idx    (srch_idx),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 256; i++) model[i] = 12'd0;
    endtask

    function automatic int find_lowest(input logic [11:0] t);
        for (int k = 0; k < 32; k++) if (model[k] == t) return k;
        return -1;
    endfunction

    task automatic check_rd(input logic [7:0] a);
        rd_addr = a;
        #1;
        chk("rd_target", 32'(rd_target), 32'(model[a]));
    endtask

    // Counts INIT cycles after reset release; target must stay zero throughout
    task automatic count_init();
        int n = 0;
        int saw_done = 0;
        int saw_nz = 0;
        while (busy && n < 100) begin
            n++;
            if (srch_done) saw_done = 1;
            if (rd_target != 12'd0) saw_nz = 1;
            tick();
        end
        chk("init_len", 32'(n), 32'd32);
        chk("init_no_done", 32'(saw_done), 32'd0);
        chk("init_rd_zero", 32'(saw_nz), 32'd0);
        chk("idle_wr_ready", 32'(wr_ready), 32'd1);
        chk("idle_busy", 32'(busy), 32'd0);
    endtask

    task automatic do_write(input logic [7:0] idx, input logic [11:0] val);
        wr_valid  = 1'b1;
        wr_idx    = idx;
        wr_target = val;
        #1;
        chk("wr_ready", 32'(wr_ready), 32'd1);
        tick();
        wr_valid = 1'b0;
        if (idx < 8'd32) model[idx] = val;
    endtask

    // Called just after the accept edge; waits for the done pulse and checks it
    task automatic wait_result(input logic [11:0] t);
        int k;
        int n;
        int exp_lat;
        int exp_idx;
        int exp_hit;
        k       = find_lowest(t);
        exp_lat = (k >= 0) ? k + 1 : 32;
        exp_hit = (k >= 0) ? 1 : 0;
        exp_idx = (k >= 0) ? k : 0;
        chk("srch_busy", 32'(busy), 32'd1);
        n = 0;
        while (!srch_done && n < 100) begin
            tick();
            n++;
        end
        chk("srch_latency", 32'(n), 32'(exp_lat));
        chk("srch_hit", 32'(srch_hit), 32'(exp_hit));
        chk("srch_idx", 32'(srch_idx), 32'(exp_idx));
        tick();
        chk("done_pulse", 32'(srch_done), 32'd0);
        chk("hit_hold", 32'(srch_hit), 32'(exp_hit));
        chk("idx_hold", 32'(srch_idx), 32'(exp_idx));
    endtask

    task automatic do_search(input logic [11:0] t);
        srch_valid  = 1'b1;
        srch_target = t;
        #1;
        chk("srch_ready", 32'(srch_ready), 32'd1);
        tick();
        srch_valid  = 1'b0;
        srch_target = 12'hABC;
        wait_result(t);
    endtask

    initial begin
        rst_n       = 1'b0;
        wr_valid    = 1'b0;
        wr_idx      = 8'd0;
        wr_target   = 12'd0;
        rd_addr     = 8'd0;
        srch_valid  = 1'b0;
        srch_target = 12'd0;
        model_clear();

        // Reset state
        tick();
        chk("rst_wr_ready", 32'(wr_ready), 32'd0);
        chk("rst_srch_ready", 32'(srch_ready), 32'd0);
        chk("rst_srch_done", 32'(srch_done), 32'd0);
        chk("rst_srch_hit", 32'(srch_hit), 32'd0);
        chk("rst_srch_idx", 32'(srch_idx), 32'd0);
        chk("rst_busy", 32'(busy), 32'd1);
        tick();
        rst_n = 1'b1;
        count_init();

        for (int a = 0; a < 256; a++) begin
            rd_addr = 8'(a);
            tick();
            chk("post_init_rd", 32'(rd_target), 32'd0);
        end

        // Directed writes, including an unbacked index
        do_write(8'd2, 12'd503);
        check_rd(8'd2);
        check_rd(8'd200);
        do_write(8'd40, 12'd77);
        check_rd(8'd40);
        chk("rd40_zero", 32'(rd_target), 32'd0);

        // Directed searches
        do_write(8'd5, 12'd315);
        do_search(12'd315);
        do_write(8'd3, 12'd6);
        do_write(8'd1, 12'd6);
        do_search(12'd6);
        do_search(12'd999);
        do_search(12'd0);

        // Write and search in the same IDLE cycle: write wins, search follows
        wr_valid    = 1'b1;
        wr_idx      = 8'd7;
        wr_target   = 12'd1234;
        srch_valid  = 1'b1;
        srch_target = 12'd1234;
        #1;
        chk("contest_srch_ready", 32'(srch_ready), 32'd0);
        chk("contest_wr_ready", 32'(wr_ready), 32'd1);
        tick();
        wr_valid = 1'b0;
        model[7] = 12'd1234;
        #1;
        chk("pending_srch_ready", 32'(srch_ready), 32'd1);
        tick();
        srch_valid = 1'b0;
        wait_result(12'd1234);
        check_rd(8'd7);

        // Randomized mix of writes, searches and reads
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 2) != 0) begin
                do_write(8'($urandom_range(0, 40)), 12'($urandom_range(0, 15)));
            end else begin
                do_search(12'($urandom_range(0, 16)));
            end
            check_rd(8'($urandom_range(0, 255)));
        end

        // Reset on the third SEARCH cycle abandons the search
        rd_addr     = 8'd2;
        srch_valid  = 1'b1;
        srch_target = 12'd999;
        tick();
        srch_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        chk("midrst_done", 32'(srch_done), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd1);
        chk("midrst_hit", 32'(srch_hit), 32'd0);
        chk("midrst_srch_ready", 32'(srch_ready), 32'd0);
        rst_n = 1'b1;
        model_clear();
        count_init();
        for (int a = 0; a < 32; a++) begin
            check_rd(8'(a));
        end
        do_search(12'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
